// File: rtl/regfile_pkg.sv
// Shared constants, address type and port-slice helper for the regfile_sb register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

    // Low bit of port `port` inside a flattened bus of `width`-bit lanes.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of regfile_sb; the register file takes the slave modport.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NUM_RD*AW-1:0]   rd_raddr_i;
    logic [NUM_RD*XLEN-1:0] rd_rdata_o;
    logic [NUM_RD-1:0]      rd_ready_o;
    logic [NUM_WR-1:0]      wr_en_i;
    logic [NUM_WR*AW-1:0]   wr_addr_i;
    logic [NUM_WR*XLEN-1:0] wr_data_i;
    logic                   iss_en_i;
    logic [AW-1:0]          iss_addr_i;
    logic                   flush_i;
    logic [NREGS-1:0]       busy_o;

    modport master (
        output rd_raddr_i, wr_en_i, wr_addr_i, wr_data_i, iss_en_i, iss_addr_i, flush_i,
        input  rd_rdata_o, rd_ready_o, busy_o
    );

    modport slave (
        input  rd_raddr_i, wr_en_i, wr_addr_i, wr_data_i, iss_en_i, iss_addr_i, flush_i,
        output rd_rdata_o, rd_ready_o, busy_o
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, priority flush > issue > writeback > hold.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NUM_WR = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_iss_en,
    input  logic [AW-1:0]        i_iss_addr,
    input  logic [NUM_WR-1:0]    i_wr_en,
    input  logic [NUM_WR*AW-1:0] i_wr_addr,
    input  logic                 i_flush,
    output logic [NREGS-1:0]     o_busy
);

    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] r_busy;

    // Decode issue and writeback into per-register set/clear masks; x0 is never marked.
    always_comb begin
        w_set = {NREGS{1'b0}};
        w_clr = {NREGS{1'b0}};
        for (int r = 1; r < NREGS; r++) begin
            w_set[r] = i_iss_en && (i_iss_addr == AW'(r));
            for (int w = 0; w < NUM_WR; w++) begin
                w_clr[r] = w_clr[r] | (i_wr_en[w] && (i_wr_addr[slice_lo(w, AW) +: AW] == AW'(r)));
            end
        end
    end

    // Busy state: a same-cycle issue is the newer producer, so set overrides clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= {NREGS{1'b0}};
        end else if (i_flush) begin
            r_busy <= {NREGS{1'b0}};
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file (x0 hardwired zero) with integrated write-pending scoreboard.
// Optional feature macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]        r_regs [NREGS];
    logic [NREGS-1:0]       w_busy;
    logic [NUM_RD*XLEN-1:0] w_rdata;
    logic [NUM_RD-1:0]      w_ready;
`ifdef REGFILE_BYPASS_EN
    logic                   w_hit;
`endif

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_iss_en   (bus.iss_en_i),
        .i_iss_addr (bus.iss_addr_i),
        .i_wr_en    (bus.wr_en_i),
        .i_wr_addr  (bus.wr_addr_i),
        .i_flush    (bus.flush_i),
        .o_busy     (w_busy)
    );

    // Array update: ports applied in ascending order so the highest index wins a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= {XLEN{1'b0}};
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (bus.wr_en_i[w] && (bus.wr_addr_i[slice_lo(w, AW) +: AW] != {AW{1'b0}})) begin
                    r_regs[bus.wr_addr_i[slice_lo(w, AW) +: AW]] <= bus.wr_data_i[slice_lo(w, XLEN) +: XLEN];
                end
            end
        end
    end

    // Read muxes: reset or x0 read zero/ready; otherwise array + busy, optionally overridden by bypass.
    always_comb begin
        w_rdata = {(NUM_RD*XLEN){1'b0}};
        w_ready = {NUM_RD{1'b1}};
`ifdef REGFILE_BYPASS_EN
        w_hit   = 1'b0;
`endif
        for (int p = 0; p < NUM_RD; p++) begin
            if (rst || (bus.rd_raddr_i[slice_lo(p, AW) +: AW] == {AW{1'b0}})) begin
                w_rdata[slice_lo(p, XLEN) +: XLEN] = {XLEN{1'b0}};
                w_ready[p]                         = 1'b1;
            end else begin
                w_rdata[slice_lo(p, XLEN) +: XLEN] = r_regs[bus.rd_raddr_i[slice_lo(p, AW) +: AW]];
                w_ready[p]                         = ~w_busy[bus.rd_raddr_i[slice_lo(p, AW) +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < NUM_WR; w++) begin
                    w_hit = bus.wr_en_i[w] &&
                            (bus.wr_addr_i[slice_lo(w, AW) +: AW] == bus.rd_raddr_i[slice_lo(p, AW) +: AW]);
                    w_rdata[slice_lo(p, XLEN) +: XLEN] = w_hit ? bus.wr_data_i[slice_lo(w, XLEN) +: XLEN]
                                                               : w_rdata[slice_lo(p, XLEN) +: XLEN];
                    w_ready[p] = w_ready[p] | w_hit;
                end
`endif
            end
        end
    end

    assign bus.rd_rdata_o = w_rdata;
    assign bus.rd_ready_o = w_ready;
    assign bus.busy_o     = w_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-driven bench for regfile_sb (2 read ports, 2 write ports, 32x32); honours REGFILE_BYPASS_EN.
module tb_regfile_sb;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        ie;
        reg_addr_t   ia;
        logic        fl;
        logic [1:0]  we;
        reg_addr_t   wa0;
        logic [31:0] wd0;
        reg_addr_t   wa1;
        logic [31:0] wd1;
        reg_addr_t   ra0;
        reg_addr_t   ra1;
    } stim_t;

    typedef struct {
        string       name;
        logic [31:0] d0;
        logic        r0;
        logic [31:0] d1;
        logic        r1;
        logic [31:0] busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb_q[$];

    regfile_sb_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) bus ();

    regfile_sb #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic stim_t st(input logic ie, input reg_addr_t ia, input logic fl, input logic [1:0] we,
                                 input reg_addr_t wa0, input logic [31:0] wd0, input reg_addr_t wa1,
                                 input logic [31:0] wd1, input reg_addr_t ra0, input reg_addr_t ra1);
        stim_t s;
        s.ie = ie; s.ia = ia; s.fl = fl; s.we = we;
        s.wa0 = wa0; s.wd0 = wd0; s.wa1 = wa1; s.wd1 = wd1;
        s.ra0 = ra0; s.ra1 = ra1;
        return s;
    endfunction

    function automatic stim_t rd(input reg_addr_t ra0, input reg_addr_t ra1);
        return st(1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, ra0, ra1);
    endfunction

    function automatic exp_t ex(input string n, input logic [31:0] d0, input logic r0,
                                input logic [31:0] d1, input logic r1, input logic [31:0] busy);
        exp_t e;
        e.name = n; e.d0 = d0; e.r0 = r0; e.d1 = d1; e.r1 = r1; e.busy = busy;
        return e;
    endfunction

    // Drive one cycle's inputs just after the edge and record what the read ports must show.
    task automatic apply(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        bus.iss_en_i   = s.ie;
        bus.iss_addr_i = s.ia;
        bus.flush_i    = s.fl;
        bus.wr_en_i    = s.we;
        bus.wr_addr_i  = {s.wa1, s.wa0};
        bus.wr_data_i  = {s.wd1, s.wd0};
        bus.rd_raddr_i = {s.ra1, s.ra0};
        sb_q.push_back(e);
    endtask

    task automatic test_reset;
        stim_t s[2];
        exp_t  e[2];
        exp_t  x;
        repeat (2) @(negedge clk);
        n_total++; if (bus.rd_rdata_o[31:0] !== 32'h0) $display("FAIL por_rdata: got %h want %h", bus.rd_rdata_o[31:0], 32'h0); else n_pass++;
        n_total++; if (bus.rd_ready_o !== 2'b11) $display("FAIL por_ready: got %b want %b", bus.rd_ready_o, 2'b11); else n_pass++;
        n_total++; if (bus.busy_o !== 32'h0) $display("FAIL por_busy: got %h want %h", bus.busy_o, 32'h0); else n_pass++;
        rst = 1'b0;
        s[0] = st(1'b1, 5'd5, 1'b0, 2'b01, 5'd6, 32'h55, 5'd0, 32'h0, 5'd6, 5'd5);
        e[0] = ex("rst_dirty", BYP ? 32'h55 : 32'h0, 1'b1, 32'h0, 1'b1, 32'h0);
        s[1] = rd(5'd6, 5'd5);
        e[1] = ex("rst_dirty_chk", 32'h55, 1'b1, 32'h0, 1'b0, 32'h20);
        for (int i = 0; i < 2; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb_q.pop_front();
            n_total++; if (bus.rd_rdata_o[31:0] !== x.d0) $display("FAIL %s rdata0: got %h want %h", x.name, bus.rd_rdata_o[31:0], x.d0); else n_pass++;
            n_total++; if (bus.rd_ready_o[0] !== x.r0) $display("FAIL %s ready0: got %b want %b", x.name, bus.rd_ready_o[0], x.r0); else n_pass++;
            n_total++; if (bus.rd_rdata_o[63:32] !== x.d1) $display("FAIL %s rdata1: got %h want %h", x.name, bus.rd_rdata_o[63:32], x.d1); else n_pass++;
            n_total++; if (bus.rd_ready_o[1] !== x.r1) $display("FAIL %s ready1: got %b want %b", x.name, bus.rd_ready_o[1], x.r1); else n_pass++;
            n_total++; if (bus.busy_o !== x.busy) $display("FAIL %s busy: got %h want %h", x.name, bus.busy_o, x.busy); else n_pass++;
        end
        // Mid-cycle asynchronous reset while a write to x6 is on the bus.
        @(posedge clk);
        #1;
        bus.wr_en_i   = 2'b01;
        bus.wr_addr_i = {5'd0, 5'd6};
        bus.wr_data_i = {32'h0, 32'h77};
        #2 rst = 1'b1;
        #1;
        n_total++; if (bus.rd_rdata_o !== 64'h0) $display("FAIL rst_async_rdata: got %h want %h", bus.rd_rdata_o, 64'h0); else n_pass++;
        n_total++; if (bus.rd_ready_o !== 2'b11) $display("FAIL rst_async_ready: got %b want %b", bus.rd_ready_o, 2'b11); else n_pass++;
        n_total++; if (bus.busy_o !== 32'h0) $display("FAIL rst_async_busy: got %h want %h", bus.busy_o, 32'h0); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        bus.wr_addr_i = {5'd0, 5'd7};
        bus.wr_data_i = {32'h0, 32'h99};
        rst = 1'b0;
        apply(rd(5'd6, 5'd7), ex("rst_first_edge", 32'h0, 1'b1, 32'h99, 1'b1, 32'h0));
        @(negedge clk);
        x = sb_q.pop_front();
        n_total++; if (bus.rd_rdata_o[31:0] !== x.d0) $display("FAIL %s rdata0: got %h want %h", x.name, bus.rd_rdata_o[31:0], x.d0); else n_pass++;
        n_total++; if (bus.rd_rdata_o[63:32] !== x.d1) $display("FAIL %s rdata1: got %h want %h", x.name, bus.rd_rdata_o[63:32], x.d1); else n_pass++;
        n_total++; if (bus.busy_o !== x.busy) $display("FAIL %s busy: got %h want %h", x.name, bus.busy_o, x.busy); else n_pass++;
    endtask

    task automatic test_raw;
        stim_t s[4];
        exp_t  e[4];
        exp_t  x;
        s[0] = st(1'b1, 5'd5, 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd0);
        e[0] = ex("raw_issue", 32'h0, 1'b1, 32'h0, 1'b1, 32'h0);
        s[1] = rd(5'd5, 5'd0);
        e[1] = ex("raw_wait", 32'h0, 1'b0, 32'h0, 1'b1, 32'h20);
        s[2] = st(1'b0, 5'd0, 1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd5, 5'd0);
        e[2] = ex("raw_wb", BYP ? 32'hDEADBEEF : 32'h0, BYP, 32'h0, 1'b1, 32'h20);
        s[3] = rd(5'd5, 5'd0);
        e[3] = ex("raw_after", 32'hDEADBEEF, 1'b1, 32'h0, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb_q.pop_front();
            n_total++; if (bus.rd_rdata_o[31:0] !== x.d0) $display("FAIL %s rdata0: got %h want %h", x.name, bus.rd_rdata_o[31:0], x.d0); else n_pass++;
            n_total++; if (bus.rd_ready_o[0] !== x.r0) $display("FAIL %s ready0: got %b want %b", x.name, bus.rd_ready_o[0], x.r0); else n_pass++;
            n_total++; if (bus.rd_rdata_o[63:32] !== x.d1) $display("FAIL %s rdata1: got %h want %h", x.name, bus.rd_rdata_o[63:32], x.d1); else n_pass++;
            n_total++; if (bus.rd_ready_o[1] !== x.r1) $display("FAIL %s ready1: got %b want %b", x.name, bus.rd_ready_o[1], x.r1); else n_pass++;
            n_total++; if (bus.busy_o !== x.busy) $display("FAIL %s busy: got %h want %h", x.name, bus.busy_o, x.busy); else n_pass++;
        end
    endtask

    task automatic test_issue_write_same;
        stim_t s[2];
        exp_t  e[2];
        exp_t  x;
        s[0] = st(1'b1, 5'd7, 1'b0, 2'b01, 5'd7, 32'h1234, 5'd0, 32'h0, 5'd7, 5'd5);
        e[0] = ex("same_cyc", BYP ? 32'h1234 : 32'h99, 1'b1, 32'hDEADBEEF, 1'b1, 32'h0);
        s[1] = rd(5'd7, 5'd5);
        e[1] = ex("same_cyc_after", 32'h1234, 1'b0, 32'hDEADBEEF, 1'b1, 32'h80);
        for (int i = 0; i < 2; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb_q.pop_front();
            n_total++; if (bus.rd_rdata_o[31:0] !== x.d0) $display("FAIL %s rdata0: got %h want %h", x.name, bus.rd_rdata_o[31:0], x.d0); else n_pass++;
            n_total++; if (bus.rd_ready_o[0] !== x.r0) $display("FAIL %s ready0: got %b want %b", x.name, bus.rd_ready_o[0], x.r0); else n_pass++;
            n_total++; if (bus.rd_rdata_o[63:32] !== x.d1) $display("FAIL %s rdata1: got %h want %h", x.name, bus.rd_rdata_o[63:32], x.d1); else n_pass++;
            n_total++; if (bus.rd_ready_o[1] !== x.r1) $display("FAIL %s ready1: got %b want %b", x.name, bus.rd_ready_o[1], x.r1); else n_pass++;
            n_total++; if (bus.busy_o !== x.busy) $display("FAIL %s busy: got %h want %h", x.name, bus.busy_o, x.busy); else n_pass++;
        end
    endtask

    task automatic test_dual_write;
        stim_t s[2];
        exp_t  e[2];
        exp_t  x;
        s[0] = st(1'b0, 5'd0, 1'b0, 2'b11, 5'd3, 32'hA, 5'd3, 32'hB, 5'd3, 5'd3);
        e[0] = ex("dual_wr", BYP ? 32'hB : 32'h0, 1'b1, BYP ? 32'hB : 32'h0, 1'b1, 32'h80);
        s[1] = rd(5'd3, 5'd7);
        e[1] = ex("dual_wr_after", 32'hB, 1'b1, 32'h1234, 1'b0, 32'h80);
        for (int i = 0; i < 2; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb_q.pop_front();
            n_total++; if (bus.rd_rdata_o[31:0] !== x.d0) $display("FAIL %s rdata0: got %h want %h", x.name, bus.rd_rdata_o[31:0], x.d0); else n_pass++;
            n_total++; if (bus.rd_ready_o[0] !== x.r0) $display("FAIL %s ready0: got %b want %b", x.name, bus.rd_ready_o[0], x.r0); else n_pass++;
            n_total++; if (bus.rd_rdata_o[63:32] !== x.d1) $display("FAIL %s rdata1: got %h want %h", x.name, bus.rd_rdata_o[63:32], x.d1); else n_pass++;
            n_total++; if (bus.rd_ready_o[1] !== x.r1) $display("FAIL %s ready1: got %b want %b", x.name, bus.rd_ready_o[1], x.r1); else n_pass++;
            n_total++; if (bus.busy_o !== x.busy) $display("FAIL %s busy: got %h want %h", x.name, bus.busy_o, x.busy); else n_pass++;
        end
    endtask

    task automatic test_flush;
        stim_t s[6];
        exp_t  e[6];
        exp_t  x;
        s[0] = st(1'b1, 5'd1, 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 5'd7);
        e[0] = ex("fl_iss1", 32'h0, 1'b1, 32'h1234, 1'b0, 32'h80);
        s[1] = st(1'b1, 5'd2, 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 5'd2);
        e[1] = ex("fl_iss2", 32'h0, 1'b0, 32'h0, 1'b1, 32'h82);
        s[2] = st(1'b1, 5'd9, 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd2, 5'd9);
        e[2] = ex("fl_iss9", 32'h0, 1'b0, 32'h0, 1'b1, 32'h86);
        s[3] = st(1'b1, 5'd4, 1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd4);
        e[3] = ex("fl_flush", 32'h0, 1'b0, 32'h0, 1'b1, 32'h286);
        s[4] = rd(5'd9, 5'd4);
        e[4] = ex("fl_after_a", 32'h0, 1'b1, 32'h0, 1'b1, 32'h0);
        s[5] = rd(5'd7, 5'd1);
        e[5] = ex("fl_after_b", 32'h1234, 1'b1, 32'h0, 1'b1, 32'h0);
        for (int i = 0; i < 6; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb_q.pop_front();
            n_total++; if (bus.rd_rdata_o[31:0] !== x.d0) $display("FAIL %s rdata0: got %h want %h", x.name, bus.rd_rdata_o[31:0], x.d0); else n_pass++;
            n_total++; if (bus.rd_ready_o[0] !== x.r0) $display("FAIL %s ready0: got %b want %b", x.name, bus.rd_ready_o[0], x.r0); else n_pass++;
            n_total++; if (bus.rd_rdata_o[63:32] !== x.d1) $display("FAIL %s rdata1: got %h want %h", x.name, bus.rd_rdata_o[63:32], x.d1); else n_pass++;
            n_total++; if (bus.rd_ready_o[1] !== x.r1) $display("FAIL %s ready1: got %b want %b", x.name, bus.rd_ready_o[1], x.r1); else n_pass++;
            n_total++; if (bus.busy_o !== x.busy) $display("FAIL %s busy: got %h want %h", x.name, bus.busy_o, x.busy); else n_pass++;
        end
    endtask

    task automatic test_x0;
        stim_t s[2];
        exp_t  e[2];
        exp_t  x;
        s[0] = st(1'b1, 5'd0, 1'b0, 2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        e[0] = ex("x0_wr_iss", 32'h0, 1'b1, 32'h0, 1'b1, 32'h0);
        s[1] = rd(5'd0, 5'd0);
        e[1] = ex("x0_after", 32'h0, 1'b1, 32'h0, 1'b1, 32'h0);
        for (int i = 0; i < 2; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb_q.pop_front();
            n_total++; if (bus.rd_rdata_o[31:0] !== x.d0) $display("FAIL %s rdata0: got %h want %h", x.name, bus.rd_rdata_o[31:0], x.d0); else n_pass++;
            n_total++; if (bus.rd_ready_o[0] !== x.r0) $display("FAIL %s ready0: got %b want %b", x.name, bus.rd_ready_o[0], x.r0); else n_pass++;
            n_total++; if (bus.rd_rdata_o[63:32] !== x.d1) $display("FAIL %s rdata1: got %h want %h", x.name, bus.rd_rdata_o[63:32], x.d1); else n_pass++;
            n_total++; if (bus.rd_ready_o[1] !== x.r1) $display("FAIL %s ready1: got %b want %b", x.name, bus.rd_ready_o[1], x.r1); else n_pass++;
            n_total++; if (bus.busy_o !== x.busy) $display("FAIL %s busy: got %h want %h", x.name, bus.busy_o, x.busy); else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        stim_t s[5];
        exp_t  e[5];
        exp_t  x;
        for (int i = 0; i < 4; i++) begin
            s[i] = st(1'b1, reg_addr_t'(20 + i), 1'b0, 2'b10, 5'd0, 32'h0, reg_addr_t'(10 + i),
                      32'h1000 + 32'(i), reg_addr_t'(10 + i), reg_addr_t'(9 + i));
            e[i] = ex("b2b", BYP ? 32'h1000 + 32'(i) : 32'h0, 1'b1,
                      (i == 0) ? 32'h0 : 32'h1000 + 32'(i - 1), 1'b1, ((32'h1 << i) - 32'h1) << 20);
        end
        s[4] = rd(5'd13, 5'd20);
        e[4] = ex("b2b_end", 32'h1003, 1'b1, 32'h0, 1'b0, 32'h00F00000);
        for (int i = 0; i < 5; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb_q.pop_front();
            n_total++; if (bus.rd_rdata_o[31:0] !== x.d0) $display("FAIL %s rdata0: got %h want %h", x.name, bus.rd_rdata_o[31:0], x.d0); else n_pass++;
            n_total++; if (bus.rd_ready_o[0] !== x.r0) $display("FAIL %s ready0: got %b want %b", x.name, bus.rd_ready_o[0], x.r0); else n_pass++;
            n_total++; if (bus.rd_rdata_o[63:32] !== x.d1) $display("FAIL %s rdata1: got %h want %h", x.name, bus.rd_rdata_o[63:32], x.d1); else n_pass++;
            n_total++; if (bus.rd_ready_o[1] !== x.r1) $display("FAIL %s ready1: got %b want %b", x.name, bus.rd_ready_o[1], x.r1); else n_pass++;
            n_total++; if (bus.busy_o !== x.busy) $display("FAIL %s busy: got %h want %h", x.name, bus.busy_o, x.busy); else n_pass++;
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.iss_en_i   = 1'b0;
        bus.iss_addr_i = 5'd0;
        bus.flush_i    = 1'b0;
        bus.wr_en_i    = 2'b00;
        bus.wr_addr_i  = 10'd0;
        bus.wr_data_i  = 64'h0;
        bus.rd_raddr_i = {5'd5, 5'd5};
        test_reset;
        test_raw;
        test_issue_write_same;
        test_dual_write;
        test_flush;
        test_x0;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with an integrated write-pending scoreboard. It is the successor to the single-write, two-read register file: read port count, write port count, width and depth are configurable, and each read reports operand readiness. It sits between decode (read and issue), and execute/writeback (write). Decode stalls on any read port whose ready flag is low.

## Interface
- XLEN, 32, register width in bits
- NREGS, 32, number of architectural registers (power of two, ≥4); register 0 is hardwired zero
- NUM_RD, 2, number of read ports (1–4)
- NUM_WR, 1, number of write ports (1–2)
- AW (localparam), $clog2(NREGS), address width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_raddr_i  in  NUM_RD*AW  read addresses; port p uses bits [p*AW +: AW]
- rd_rdata_o  out  NUM_RD*XLEN  read data, combinational
- rd_ready_o  out  NUM_RD  port p operand valid (no pending write outstanding)
- wr_en_i  in  NUM_WR  write enables
- wr_addr_i  in  NUM_WR*AW  write addresses
- wr_data_i  in  NUM_WR*XLEN  write data
- iss_en_i  in  1  an instruction with a destination is issued this cycle
- iss_addr_i  in  AW  destination of the issued instruction
- flush_i  in  1  pipeline flush; discards all pending marks
- busy_o  out  NREGS  scoreboard bits, registered; bit 0 always 0

## Operation
- Reset, asynchronous: every register is 0 and every busy bit is 0.
  - While rst is high, rd_rdata_o is all-zero and rd_ready_o is all-ones.
- Read port p, evaluated in priority order:
  - address 0: data 0, ready 1;
  - bypass hit (see Configuration): data is the forwarded write data, ready 1;
  - otherwise: data is regs[addr], ready is !busy[addr].
- Write: on each edge, each enabled port with a nonzero address stores its data.
  - If two ports target the same address, the higher-index port wins.
  - Writes to address 0 are dropped.
- Scoreboard, per register r ≠ 0, next busy[r] in priority order:
  - flush_i high: 0, including an issue in the same cycle;
  - iss_en_i high with iss_addr_i == r: 1. Issue beats a same-cycle write to r, because it is a newer producer.
  - any enabled write port to r: 0;
  - otherwise: hold.
- Issue to address 0 is ignored. Issue to a register that is already busy keeps it busy; there is no counting of multiple producers.
- Writes are performed regardless of flush_i and of busy state.

## Timing
- Read path is purely combinational; there is zero-cycle read latency.
- A write is visible in the array one edge after wr_en_i.
- Issue at edge N: busy set after N, so reads of that register are not ready from cycle N+1.
- Writeback in cycle M:
  - with bypass, ready and correct data appear in cycle M itself;
  - without bypass, they appear in cycle M+1.
- Flush in cycle F: all busy_o bits are 0 after edge F.
- rst asserted mid-operation clears all state immediately. The first edge after deassertion behaves as a normal cycle.

## Configuration
- REGFILE_BYPASS_EN defined: a read port whose address matches an enabled write port in the same cycle returns that port's wr_data_i (highest matching index) with ready 1.
- Not defined: there is no write-to-read forwarding. Reads return the array value and ready follows busy, adding one cycle to the RAW turnaround.
- The scoreboard is unaffected by the macro.

## Structure
- Package regfile_pkg holds:
  - default XLEN/NREGS constants;
  - helper function for the port slice index;
  - typedef for the register address.
- Sub-module regfile_scoreboard holds the NREGS busy bits and their set/clear/flush priority logic.
  - Inputs: issue, write enables and addresses, flush.
  - Output: busy vector.
- Top level holds the data array, write-port merge and read muxes/bypass.

## Test plan
- Reset: rst=1 asynchronously mid-cycle, then read x5 → data 0, ready 1, busy_o=0.
- Issue x5, write x5=0xDEADBEEF two cycles later:
  - port 0 reading x5 shows ready 0 for cycles N+1..M−1;
  - ready 1 with 0xDEADBEEF in cycle M (bypass) or M+1 (no bypass).
- Same-cycle issue x7 and write x7=0x1234:
  - busy[7] stays 1;
  - array x7 becomes 0x1234.
- Dual write (NUM_WR=2) to x3 with 0xA on port 0 and 0xB on port 1 → x3 = 0xB; with bypass a same-cycle read returns 0xB.
- Flush with x1, x2, x9 busy plus same-cycle issue of x4 → busy_o=0 next cycle; all reads ready.
- Write x0=0xFFFFFFFF and issue x0 → x0 reads 0, ready 1, busy_o[0]=0 throughout.
